// File: rtl/exe_muldiv_if.sv
// exe_muldiv_if: execute-stage handshake and HI/LO bus between the pipeline (master) and the mul/div unit (slave)
interface exe_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A_IN;
  logic [WIDTH-1:0] B_IN;
  logic             read_req;
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] HI_OUT;
  logic [WIDTH-1:0] LO_OUT;
  logic             busy;
  logic             done;
  logic             stall_req;
  modport master (
    output start, op, A_IN, B_IN, read_req, stall, flush,
    input  HI_OUT, LO_OUT, busy, done, stall_req
  );
  modport slave (
    input  start, op, A_IN, B_IN, read_req, stall, flush,
    output HI_OUT, LO_OUT, busy, done, stall_req
  );
endinterface

// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative shift-add multiply / restoring divide owning HI/LO; MULDIV_EARLY_OUT_EN lets multiplies finish once the multiplier is exhausted
module exe_muldiv #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic         CLK,
  input logic         RESET,
  exe_muldiv_if.slave bus
);
  localparam int W     = WIDTH;
  localparam int B     = BITS_PER_CYCLE;
  localparam int STEPS = W / B;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t         state, state_nx;
  logic [2*W-1:0] acc, acc_step, acc_fin, prod;
  logic [W-1:0]   d, hi, lo, rem_t, quo_t, rem_fix, mag_a, mag_b;
  logic [W:0]     tmp;
  logic [W+B-1:0] sum;
  logic [CW-1:0]  cnt;
  logic           done_r, is_div, neg_q, neg_r, div0, early;
  logic           accept, go_md, sgn;

  assign accept = bus.start && !bus.stall && state == IDLE && !bus.flush;
  assign go_md  = accept && !bus.op[2];
  assign sgn    = !bus.op[0];
  assign mag_a  = (sgn && bus.A_IN[W-1]) ? -bus.A_IN : bus.A_IN;
  assign mag_b  = (sgn && bus.B_IN[W-1]) ? -bus.B_IN : bus.B_IN;

  // One iteration: multiply adds d*digit into the upper half then shifts right; divide runs B restoring steps on {rem, quo}
  always_comb begin
    rem_t = acc[2*W-1:W];
    quo_t = acc[W-1:0];
    tmp   = '0;
    sum   = {{B{1'b0}}, acc[2*W-1:W]} + ({{B{1'b0}}, d} * {{W{1'b0}}, acc[B-1:0]});
    for (int k = 0; k < B; k++) begin
      tmp   = {rem_t, quo_t[W-1]};
      quo_t = {quo_t[W-2:0], tmp >= {1'b0, d}};
      tmp   = quo_t[0] ? tmp - {1'b0, d} : tmp;
      rem_t = tmp[W-1:0];
    end
    acc_step = is_div ? {rem_t, quo_t} : {sum, acc[W-1:B]};
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic [W-1:0] mask;
  int           sh;
  // The cnt remaining steps would only shift zeros in, so exit and apply that shift at once
  always_comb begin
    sh      = B * int'(cnt);
    mask    = ~({W{1'b1}} << sh);
    early   = !is_div && (acc_step[W-1:0] & mask) == '0;
    acc_fin = early ? acc_step >> sh : acc_step;
  end
`else
  assign early   = 1'b0;
  assign acc_fin = acc_step;
`endif

  assign prod    = neg_q ? -acc : acc;
  assign rem_fix = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: flush wins over everything, RUN ends on the last step or an early exit
  always_comb begin
    state_nx = state;
    state_nx = bus.flush                                ? IDLE :
               (state == IDLE && go_md)                 ? RUN  :
               (state == RUN && (cnt == '0 || early))   ? FIX  :
               state == FIX                             ? IDLE : state;
  end

  // Operand latch, iteration datapath and HI/LO commit
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      acc    <= '0;
      d      <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      done_r <= 1'b0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept && bus.op == 3'd4) hi <= bus.A_IN;
      if (accept && bus.op == 3'd5) lo <= bus.A_IN;
      if (go_md) begin
        is_div <= bus.op[1];
        neg_q  <= sgn && (bus.A_IN[W-1] ^ bus.B_IN[W-1]);
        neg_r  <= sgn && bus.A_IN[W-1];
        div0   <= bus.B_IN == '0;
        d      <= bus.op[1] ? mag_b : mag_a;
        acc    <= {{W{1'b0}}, bus.op[1] ? mag_a : mag_b};
        cnt    <= CW'(STEPS - 1);
      end
      if (state == RUN && !bus.flush) begin
        acc <= acc_fin;
        cnt <= (cnt == '0 || early) ? '0 : cnt - 1'b1;
      end
      if (state == FIX && !bus.flush) begin
        hi     <= is_div ? rem_fix : prod[2*W-1:W];
        lo     <= (is_div && div0) ? '1 : prod[W-1:0];
        done_r <= 1'b1;
      end
    end
  end

  assign bus.HI_OUT    = hi;
  assign bus.LO_OUT    = lo;
  assign bus.busy      = state != IDLE;
  assign bus.done      = done_r;
  assign bus.stall_req = bus.busy && (bus.read_req || bus.start);
endmodule

// File: doc/exe_muldiv.md
# exe_muldiv

Parametrised iterative multiply/divide unit with architectural HI/LO registers, which takes over the HI/LO state held inside the execute stage. The execute stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO through a start handshake. The unit computes over multiple cycles, independently of pipeline stalls, and raises a stall request whenever the pipeline needs HI/LO before the result is ready. A flush aborts an in-flight operation.

## Interface
- WIDTH, 32: operand and HI/LO width.
- BITS_PER_CYCLE, 1: bits retired per iteration. Legal values are 1, 2 or 4, and the value must divide WIDTH.
- CLK  input  1  clock. All state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- start  input  1  issue the operation on op using A_IN and B_IN.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO. Codes 6 and 7 are ignored.
- A_IN  input  WIDTH  multiplicand, or dividend, or the MTHI/MTLO source.
- B_IN  input  WIDTH  multiplier or divisor.
- read_req  input  1  the instruction currently in the execute stage reads HI or LO (MFHI/MFLO).
- stall  input  1  pipeline freeze from the cache/memory side.
- flush  input  1  discard any in-flight operation.
- HI_OUT  output  WIDTH  architectural HI.
- LO_OUT  output  WIDTH  architectural LO.
- busy  output  1  an operation is in flight.
- done  output  1  one-cycle pulse on the cycle after HI/LO are committed.
- stall_req  output  1  combinational: busy && (read_req || start).

## Operation
- Reset values: HI_OUT=0, LO_OUT=0, busy=0, done=0, state=IDLE, iteration counter=0.
- Definitions:
  - STEPS = WIDTH/BITS_PER_CYCLE.
  - An accepted start = start && !stall && !busy && !flush.
- IDLE state:
  - MTHI/MTLO accepted: HI or LO is written from A_IN on that edge. State stays IDLE and busy stays 0.
  - MULT/MULTU/DIV/DIVU accepted: operands are latched and state goes to RUN.
  - For signed ops the magnitudes are latched, together with sign flags: product sign = signA^signB; quotient sign = signA^signB; remainder sign = signA.
- RUN state:
  - Multiply is shift-add and consumes BITS_PER_CYCLE multiplier bits per cycle into a 2*WIDTH accumulator.
  - Divide is restoring and resolves BITS_PER_CYCLE quotient bits per cycle.
  - The counter runs from STEPS-1 down to 0. When it reaches 0 the state goes to FIX.
- FIX state:
  - Apply two's-complement sign correction.
  - Commit the results: multiply gives HI=product[2W-1:W] and LO=product[W-1:0]; divide gives LO=quotient and HI=remainder.
  - Set done=1 for one cycle and return to IDLE.
- Divide by zero: LO=all ones, HI=dividend (the original signed value for DIV). This is deterministic and has no exception.
- Signed overflow (most negative value / -1): LO=most negative value, HI=0.
- stall has no effect once busy. Computation continues while the pipeline is frozen.
- flush, at any state: the next edge returns the unit to IDLE with busy=0. HI/LO are unchanged and done stays 0. flush has priority over both start and FIX commit.
- A start while busy is never accepted. stall_req holds the pipeline so the instruction is re-presented after done.

## Timing
- Accepted MULT/DIV start sampled on edge t0:
  - busy=1 from t0.
  - HI/LO update on edge t0+STEPS+1.
  - busy falls and done rises on that same edge.
- Total latency is STEPS+1 cycles: 33 for WIDTH=32 and BITS_PER_CYCLE=1; 9 for BITS_PER_CYCLE=4.
- MTHI/MTLO: 1 cycle. The new value is visible on HI_OUT/LO_OUT after the sampling edge.
- On the done cycle, read_req sees the committed HI/LO with stall_req=0. A new start is accepted on that cycle.
- If an asynchronous RESET lands mid-operation, all state returns immediately to reset values and the partial result is lost.

## Configuration
- MULDIV_EARLY_OUT_EN defined:
  - Multiply leaves RUN for FIX as soon as the remaining unconsumed multiplier magnitude bits are all zero.
  - On leaving, the accumulator is aligned by the skipped shift.
  - A multiplier of 0 or 1 reaches FIX after 1 RUN cycle (latency 2).
  - Divide latency is unaffected.
- MULDIV_EARLY_OUT_EN undefined: every MULT/MULTU/DIV/DIVU has fixed latency STEPS+1.

## Test plan
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. done exactly 33 cycles after start (WIDTH=32, BPC=1, early-out off).
- MULT -7*3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
- Start DIVU 100/7, hold read_req from cycle 2 -> stall_req=1 until the done cycle, then HI=2 and LO=14. Toggling stall mid-RUN does not change the latency.
- Start MULT, assert flush at cycle 10 -> busy=0 next edge, HI/LO keep prior values, no done. An MTLO 0x1234 on the following cycle -> LO=0x1234 after one edge.
- With MULDIV_EARLY_OUT_EN, MULTU 0x12345678*1 -> LO=0x12345678, HI=0, done 2 cycles after start. Repeat with BITS_PER_CYCLE=4, early-out off -> done after 9 cycles.
